// File: rtl/enemy_sprite_renderer.sv
// Erase/move/redraw sequencer for one enemy sprite, driving the VGA adapter pixel port.
// Each frame: erase the old box in the background colour, request one move, then redraw.
module enemy_sprite_renderer #(
  parameter int unsigned SPRITE_W  = 4,
  parameter int unsigned SPRITE_H  = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] enemy_x,
  input  logic [6:0] enemy_y,
  input  logic [2:0] enemy_colour,
  input  logic       done_update,
  output logic       update_enemy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       frame_done
);

  typedef enum logic [2:0] {StIdle, StErase, StReq, StLatch, StDraw, StDone} state_e;

  localparam logic [2:0] LastPx = 3'(SPRITE_W - 1);
  localparam logic [2:0] LastPy = 3'(SPRITE_H - 1);

  state_e     state_q;
  logic       drawn_q;
  logic [7:0] old_x_q;
  logic [6:0] old_y_q;
  logic [2:0] px_q, py_q;

  logic [2:0]  nx_px, nx_py;
  logic        last_pixel;
  logic [15:0] step_pix, erase_start, draw_start;

  // Packs {visible, x[7:0], y[6:0]}; sums are widened so off-screen pixels never wrap on-screen.
  function automatic logic [15:0] pixel(input logic [7:0] bx, input logic [6:0] by,
                                        input logic [2:0] cx, input logic [2:0] cy);
    logic [8:0] sx;
    logic [7:0] sy;
    logic       vis;
    sx  = {1'b0, bx} + {6'd0, cx};
    sy  = {1'b0, by} + {5'd0, cy};
    vis = (32'(sx) < SCREEN_W) && (32'(sy) < SCREEN_H);
    return {vis, sx[7:0], sy[6:0]};
  endfunction

  always_comb begin
    nx_px = px_q + 3'd1;
    nx_py = py_q;
    if (px_q == LastPx) begin
      nx_px = 3'd0;
      nx_py = py_q + 3'd1;
    end
  end

  assign last_pixel  = (px_q == LastPx) && (py_q == LastPy);
  assign step_pix    = pixel(old_x_q, old_y_q, nx_px, nx_py);
  assign erase_start = pixel(old_x_q, old_y_q, 3'd0, 3'd0);
  assign draw_start  = pixel(enemy_x, enemy_y, 3'd0, 3'd0);

  // Outputs are computed one cycle ahead so each presented pixel lines up with its state cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      drawn_q      <= 1'b0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      px_q         <= '0;
      py_q         <= '0;
      update_enemy <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      plot         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            if (drawn_q) begin
              state_q                <= StErase;
              px_q                   <= '0;
              py_q                   <= '0;
              {plot, vga_x, vga_y}   <= erase_start;
              vga_colour             <= BG_COLOUR;
            end else begin
              state_q <= StLatch;
            end
          end
        end
        StErase: begin
          if (last_pixel) begin
            state_q      <= StReq;
            plot         <= 1'b0;
            update_enemy <= 1'b1;
          end else begin
            px_q                 <= nx_px;
            py_q                 <= nx_py;
            {plot, vga_x, vga_y} <= step_pix;
          end
        end
        StReq: begin
          if (done_update) begin
            update_enemy <= 1'b0;
            state_q      <= StLatch;
          end
        end
        StLatch: begin
          old_x_q              <= enemy_x;
          old_y_q              <= enemy_y;
          px_q                 <= '0;
          py_q                 <= '0;
          {plot, vga_x, vga_y} <= draw_start;
          vga_colour           <= enemy_colour;
          state_q              <= StDraw;
        end
        StDraw: begin
          if (last_pixel) begin
            state_q    <= StDone;
            plot       <= 1'b0;
            drawn_q    <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            px_q                 <= nx_px;
            py_q                 <= nx_py;
            {plot, vga_x, vga_y} <= step_pix;
          end
        end
        StDone: begin
          frame_done <= 1'b0;
          if (run) begin
            state_q              <= StErase;
            px_q                 <= '0;
            py_q                 <= '0;
            {plot, vga_x, vga_y} <= erase_start;
            vga_colour           <= BG_COLOUR;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_sprite_renderer.sv
// Bench for enemy_sprite_renderer: directed frame sequence with randomized positions, colours
// and datapath latency, checked against a frame-level model of positions and pixel boxes.
module tb_enemy_sprite_renderer;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset, run, done_update;
  logic [7:0] enemy_x, vga_x;
  logic [6:0] enemy_y, vga_y;
  logic [2:0] enemy_colour, vga_colour;
  logic       update_enemy, plot, frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int m_ox  = 0;
  int m_oy  = 0;
  bit m_drawn = 1'b0;

  always #5 clk = ~clk;

  enemy_sprite_renderer #(
    .SPRITE_W (W),
    .SPRITE_H (H),
    .BG_COLOUR(3'b000),
    .SCREEN_W (160),
    .SCREEN_H (120)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .enemy_colour(enemy_colour),
    .done_update (done_update),
    .update_enemy(update_enemy),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .plot        (plot),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pixel k of a box anchored at (bx,by): raster order, clipped at the screen edge.
  task automatic check_pixel(input string what, input int k, input int bx, input int by,
                             input int col);
    int sx, sy;
    sx = bx + k % W;
    sy = by + k / W;
    chk($sformatf("%s[%0d] plot", what, k), plot, (sx < 160 && sy < 120) ? 1 : 0);
    chk($sformatf("%s[%0d] x", what, k), vga_x, sx % 256);
    chk($sformatf("%s[%0d] y", what, k), vga_y, sy % 128);
    chk($sformatf("%s[%0d] colour", what, k), vga_colour, col);
  endtask

  // Called at the falling edge of the cycle just before a frame starts (IDLE with run, or DONE).
  task automatic do_frame(input int ex, input int ey, input int col, input int delay,
                          input bit drop_run, input bit glitch, input int rst_at);
    int seen;
    enemy_colour = col[2:0];
    if (!m_drawn) begin
      enemy_x = ex[7:0];
      enemy_y = ey[6:0];
    end
    if (m_drawn) begin
      for (int k = 0; k < W * H; k++) begin
        @(negedge clk);
        check_pixel("erase", k, m_ox, m_oy, 0);
        chk("erase update", update_enemy, 0);
        if (drop_run && k == 0) run = 1'b0;
      end
      seen = 0;
      for (int c = 0; c < 300 && done_update == 1'b0; c++) begin
        @(negedge clk);
        chk("req update", update_enemy, 1);
        chk("req plot", plot, 0);
        seen++;
        if (seen == delay + 1) begin
          done_update = 1'b1;
          enemy_x     = ex[7:0];
          enemy_y     = ey[6:0];
        end
      end
      chk("req length", seen, delay + 1);
      @(negedge clk);
      done_update = 1'b0;
      chk("latch update", update_enemy, 0);
    end else begin
      @(negedge clk);
    end
    chk("latch plot", plot, 0);
    chk("latch frame_done", frame_done, 0);
    m_ox = ex;
    m_oy = ey;
    for (int k = 0; k < W * H; k++) begin
      @(negedge clk);
      check_pixel("draw", k, m_ox, m_oy, col);
      chk("draw update", update_enemy, 0);
      if (glitch && k == 2) begin
        done_update = 1'b1;
        enemy_x     = 8'($urandom);
        enemy_y     = 7'($urandom);
      end
      if (glitch && k == 3) done_update = 1'b0;
      if (k == rst_at) begin
        reset = 1'b0;
        #1;
        chk("rst plot", plot, 0);
        chk("rst update", update_enemy, 0);
        chk("rst frame_done", frame_done, 0);
        @(negedge clk);
        reset   = 1'b1;
        m_drawn = 1'b0;
        m_ox    = 0;
        m_oy    = 0;
        return;
      end
    end
    @(negedge clk);
    chk("done pulse", frame_done, 1);
    chk("done plot", plot, 0);
    m_drawn = 1'b1;
    if (!run) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("idle plot", plot, 0);
        chk("idle frame_done", frame_done, 0);
        chk("idle update", update_enemy, 0);
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    run          = 1'b0;
    done_update  = 1'b0;
    enemy_x      = '0;
    enemy_y      = '0;
    enemy_colour = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset plot", plot, 0);
    chk("reset update", update_enemy, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset x", vga_x, 0);
    chk("reset y", vga_y, 0);
    chk("reset colour", vga_colour, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle no run plot", plot, 0);

    run = 1'b1;
    do_frame(140, 10, 4, 0, 1'b0, 1'b0, -1);
    do_frame(139, 10, 4, 5, 1'b0, 1'b0, -1);
    do_frame(158, 118, $urandom_range(1, 7), $urandom_range(0, 4), 1'b0, 1'b0, -1);
    do_frame($urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 7),
             $urandom_range(0, 4), 1'b0, 1'b1, -1);
    do_frame($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
             $urandom_range(0, 6), 1'b0, 1'b0, -1);
    do_frame($urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 7),
             2, 1'b1, 1'b0, -1);

    run = 1'b1;
    for (int f = 0; f < 3; f++) begin
      do_frame($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
               $urandom_range(0, 8), 1'b0, 1'b0, -1);
    end
    do_frame(20, 30, 5, 3, 1'b0, 1'b0, 6);
    do_frame($urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(1, 7),
             0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
